// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, exception
// cause codes, default address constants and the branch-offset helper.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_UPDATE,
        ST_HALTED
    } seq_state_t;

    localparam logic [4:0] CAUSE_ADEL = 5'd4;
    localparam logic [4:0] CAUSE_IBE  = 5'd6;
    localparam logic [4:0] CAUSE_SYS  = 5'd8;
    localparam logic [4:0] CAUSE_BP   = 5'd9;
    localparam logic [4:0] CAUSE_TR   = 5'd13;

    localparam logic [31:0] DEF_RESET_PC      = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR    = 32'h0040_0004;
    localparam int          DEF_FETCH_TIMEOUT = 8;

    // Word offset to byte offset, sign-extended to a full address
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Bundle of the control-unit, instruction-memory and PC-register signals
// around the sequencer. The sequencer takes the master view; the
// surrounding datapath/control side takes the slave view.
interface pc_seq_ctrl_if;

    logic [31:0] pc_cur;
    logic        imem_ready;
    logic        exec_busy;
    logic        br_taken;
    logic [15:0] br_imm;
    logic        j_en;
    logic [25:0] j_index;
    logic        jr_en;
    logic [31:0] jr_addr;
    logic        eret_en;
    logic        exc_req;
    logic [4:0]  exc_cause_in;
    logic        halt;

    logic        imem_req;
    logic        ir_we;
    logic        pc_ena;
    logic [31:0] pc_next;
    logic [31:0] epc_out;
    logic [4:0]  cause_out;
    logic        epc_we;
    logic        halted;

    modport master (
        input  pc_cur, imem_ready, exec_busy, br_taken, br_imm, j_en, j_index,
               jr_en, jr_addr, eret_en, exc_req, exc_cause_in, halt,
        output imem_req, ir_we, pc_ena, pc_next, epc_out, cause_out, epc_we, halted
    );

    modport slave (
        output pc_cur, imem_ready, exec_busy, br_taken, br_imm, j_en, j_index,
               jr_en, jr_addr, eret_en, exc_req, exc_cause_in, halt,
        input  imem_req, ir_we, pc_ena, pc_next, epc_out, cause_out, epc_we, halted
    );

endinterface

// File: rtl/pc_next_mux.sv
// Purely combinational next-PC selection. A fetch error outranks everything
// because no instruction word exists to give the other controls meaning;
// after that the datapath exception, misaligned jr, eret, jr, j, branch and
// finally the sequential PC. All arithmetic wraps modulo 2^32.
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] pc_cur,
    input  logic [31:0] epc,
    input  logic        fetch_err,
    input  logic        exc_req,
    input  logic [4:0]  exc_cause_in,
    input  logic        jr_en,
    input  logic [31:0] jr_addr,
    input  logic        eret_en,
    input  logic        j_en,
    input  logic [25:0] j_index,
    input  logic        br_taken,
    input  logic [15:0] br_imm,
    output logic [31:0] pc_sel,
    output logic        exc_take,
    output logic [4:0]  exc_cause
);

    logic [31:0] pc4;
    logic        jr_misaligned;

    assign pc4           = pc_cur + 32'd4;
    assign jr_misaligned = jr_en && (jr_addr[1:0] != 2'b00);

    // Priority select of the next PC and whether EPC/cause must be captured
    always_comb begin
        pc_sel    = pc4;
        exc_take  = 1'b0;
        exc_cause = 5'd0;
        if (fetch_err) begin
            pc_sel    = EXC_VECTOR;
            exc_take  = 1'b1;
            exc_cause = CAUSE_IBE;
        end else if (exc_req) begin
            pc_sel    = EXC_VECTOR;
            exc_take  = 1'b1;
            exc_cause = exc_cause_in;
        end else if (jr_misaligned) begin
            pc_sel    = EXC_VECTOR;
            exc_take  = 1'b1;
            exc_cause = CAUSE_ADEL;
        end else if (eret_en) begin
            pc_sel = epc;
        end else if (jr_en) begin
            pc_sel = jr_addr;
        end else if (j_en) begin
            pc_sel = {pc4[31:28], j_index, 2'b00};
        end else if (br_taken) begin
            pc_sel = pc4 + branch_offset(br_imm);
        end
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multicycle instruction sequencer: IDLE -> FETCH -> EXEC -> UPDATE, looping
// back to FETCH or parking in HALTED. Drives the PC register enable/data and
// holds EPC/cause for the exception path.
// Optional macro PC_FETCH_TIMEOUT_EN: abandon a FETCH that waits
// FETCH_TIMEOUT cycles and take an instruction bus error (cause 6).
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
`ifdef PC_FETCH_TIMEOUT_EN
    , parameter int        FETCH_TIMEOUT = DEF_FETCH_TIMEOUT
`endif
) (
    input  logic          clk,
    input  logic          rst,
    pc_seq_ctrl_if.master bus
);

    seq_state_t  state;
    logic        imem_req_r;
    logic        pc_ena_r;
    logic        halted_r;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic [31:0] pc_hold;
    logic        fetch_err;
    logic [31:0] mux_pc;
    logic        mux_exc;
    logic [4:0]  mux_cause;

`ifdef PC_FETCH_TIMEOUT_EN
    localparam int             CNT_W    = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);
    logic [CNT_W-1:0] fetch_cnt;
`else
    assign fetch_err = 1'b0;
`endif

    pc_next_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_mux (
        .pc_cur       (bus.pc_cur),
        .epc          (epc),
        .fetch_err    (fetch_err),
        .exc_req      (bus.exc_req),
        .exc_cause_in (bus.exc_cause_in),
        .jr_en        (bus.jr_en),
        .jr_addr      (bus.jr_addr),
        .eret_en      (bus.eret_en),
        .j_en         (bus.j_en),
        .j_index      (bus.j_index),
        .br_taken     (bus.br_taken),
        .br_imm       (bus.br_imm),
        .pc_sel       (mux_pc),
        .exc_take     (mux_exc),
        .exc_cause    (mux_cause)
    );

    // Sequencer FSM with registered phase strobes and EPC/cause capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            imem_req_r <= 1'b0;
            pc_ena_r   <= 1'b0;
            halted_r   <= 1'b0;
            epc        <= RESET_PC;
            cause      <= 5'd0;
            pc_hold    <= RESET_PC;
`ifdef PC_FETCH_TIMEOUT_EN
            fetch_err  <= 1'b0;
            fetch_cnt  <= '0;
`endif
        end else begin
            imem_req_r <= 1'b0;
            pc_ena_r   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state      <= ST_FETCH;
                    imem_req_r <= 1'b1;
`ifdef PC_FETCH_TIMEOUT_EN
                    fetch_cnt  <= '0;
`endif
                end
                ST_FETCH: begin
                    if (bus.imem_ready) begin
                        state <= ST_EXEC;
`ifdef PC_FETCH_TIMEOUT_EN
                    end else if (fetch_cnt == CNT_LAST) begin
                        state     <= ST_UPDATE;
                        pc_ena_r  <= 1'b1;
                        fetch_err <= 1'b1;
                    end else begin
                        fetch_cnt  <= fetch_cnt + CNT_W'(1);
                        imem_req_r <= 1'b1;
`else
                    end else begin
                        imem_req_r <= 1'b1;
`endif
                    end
                end
                ST_EXEC: begin
                    if (!bus.exec_busy) begin
                        state    <= ST_UPDATE;
                        pc_ena_r <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    pc_hold <= mux_pc;
                    if (mux_exc) begin
                        epc   <= bus.pc_cur;
                        cause <= mux_cause;
                    end
`ifdef PC_FETCH_TIMEOUT_EN
                    fetch_err <= 1'b0;
                    fetch_cnt <= '0;
`endif
                    if (bus.halt) begin
                        state    <= ST_HALTED;
                        halted_r <= 1'b1;
                    end else begin
                        state      <= ST_FETCH;
                        imem_req_r <= 1'b1;
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are masked while reset is asserted so an aborted UPDATE never
    // reaches the PC register or the EPC consumer
    assign bus.imem_req  = imem_req_r & rst;
    assign bus.ir_we     = imem_req_r & bus.imem_ready & rst;
    assign bus.pc_ena    = pc_ena_r & rst;
    assign bus.epc_we    = pc_ena_r & mux_exc & rst;
    assign bus.pc_next   = pc_ena_r ? mux_pc : pc_hold;
    assign bus.epc_out   = epc;
    assign bus.cause_out = cause;
    assign bus.halted    = halted_r;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: a hand-computed vector table, a
// randomized run against a next-PC reference model, reset-abort, halt and
// fetch-timeout sequences (PC_FETCH_TIMEOUT_EN selects the timeout variant).
module tb_pc_seq_ctrl;

    localparam logic [31:0] RESET_PC_TB = 32'h0040_0000;
    localparam logic [31:0] EXC_VEC_TB  = 32'h0040_0004;

    typedef struct {
        logic [31:0] pc_cur;
        logic        br_taken;
        logic [15:0] br_imm;
        logic        j_en;
        logic [25:0] j_index;
        logic        jr_en;
        logic [31:0] jr_addr;
        logic        eret_en;
        logic        exc_req;
        logic [4:0]  exc_cause;
        logic        halt;
        int          rdy;
        int          busy;
    } instr_t;

    typedef struct {
        instr_t      in;
        logic [31:0] exp_pc;
        logic        exp_we;
        logic [31:0] exp_epc;
        logic [4:0]  exp_cause;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_epc = RESET_PC_TB;
    logic [4:0]  exp_cause = 5'd0;
    vec_t        vecs[14];

    pc_seq_ctrl_if bus();

    pc_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic instr_t mk(input logic [31:0] pc, input logic br, input logic [15:0] imm,
                                  input logic j, input logic [25:0] jidx, input logic jr,
                                  input logic [31:0] jaddr, input logic eret, input logic exc,
                                  input logic [4:0] cause, input int rdy, input int busy);
        instr_t r;
        r.pc_cur = pc;  r.br_taken = br;  r.br_imm = imm;   r.j_en = j;
        r.j_index = jidx; r.jr_en = jr;   r.jr_addr = jaddr; r.eret_en = eret;
        r.exc_req = exc; r.exc_cause = cause; r.halt = 1'b0; r.rdy = rdy; r.busy = busy;
        return r;
    endfunction

    // Next PC straight from the architectural rules, using integer offsets
    function automatic logic [31:0] modelPc(input instr_t in, input logic [31:0] epc);
        logic [31:0] pc4;
        int          off;
        pc4 = in.pc_cur + 32'd4;
        if (in.exc_req || (in.jr_en && in.jr_addr[1:0] != 2'b00)) return EXC_VEC_TB;
        if (in.eret_en) return epc;
        if (in.jr_en) return in.jr_addr;
        if (in.j_en) return (pc4 & 32'hF000_0000) | ({6'd0, in.j_index} * 4);
        if (in.br_taken) begin
            off = $signed(in.br_imm) * 4;
            return pc4 + 32'(off);
        end
        return pc4;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual 0x%08h required 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic driveCtrl(input instr_t in);
        bus.pc_cur = in.pc_cur;   bus.br_taken = in.br_taken; bus.br_imm = in.br_imm;
        bus.j_en = in.j_en;       bus.j_index = in.j_index;   bus.jr_en = in.jr_en;
        bus.jr_addr = in.jr_addr; bus.eret_en = in.eret_en;   bus.exc_req = in.exc_req;
        bus.exc_cause_in = in.exc_cause; bus.halt = in.halt;
    endtask

    // One full instruction starting in FETCH; random noise on exc_req and
    // the handshakes outside their phase must have no effect
    task automatic applyStimulus(input instr_t in, input logic [31:0] exp_pc, input logic exp_we);
        for (int k = 0; k <= in.rdy; k++) begin
            @(negedge clk);
            driveCtrl(in);
            bus.exc_req    = 1'($urandom);
            bus.exec_busy  = 1'($urandom);
            bus.imem_ready = (k == in.rdy);
            #1;
            if (k == 0) begin
                checkOutput("epc_out", bus.epc_out, exp_epc);
                checkOutput("cause_out", 32'(bus.cause_out), 32'(exp_cause));
            end
            checkOutput("fetch_imem_req", 32'(bus.imem_req), 32'd1);
            checkOutput("fetch_ir_we", 32'(bus.ir_we), 32'(k == in.rdy));
            checkOutput("fetch_pc_ena", 32'(bus.pc_ena), 32'd0);
            checkOutput("fetch_epc_we", 32'(bus.epc_we), 32'd0);
        end
        for (int k = 0; k <= in.busy; k++) begin
            @(negedge clk);
            driveCtrl(in);
            bus.exc_req    = 1'($urandom);
            bus.imem_ready = 1'($urandom);
            bus.exec_busy  = (k < in.busy);
            #1;
            checkOutput("exec_pc_ena", 32'(bus.pc_ena), 32'd0);
            checkOutput("exec_ir_we", 32'(bus.ir_we), 32'd0);
            checkOutput("exec_epc_we", 32'(bus.epc_we), 32'd0);
        end
        @(negedge clk);
        driveCtrl(in);
        bus.imem_ready = 1'($urandom);
        bus.exec_busy  = 1'($urandom);
        #1;
        checkOutput("upd_pc_ena", 32'(bus.pc_ena), 32'd1);
        checkOutput("upd_pc_next", bus.pc_next, exp_pc);
        checkOutput("upd_epc_we", 32'(bus.epc_we), 32'(exp_we));
        checkOutput("upd_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("upd_halted", 32'(bus.halted), 32'd0);
    endtask

    // Assert reset for one edge (aborting whatever is in flight), then
    // release and check the IDLE cycle
    task automatic resetSeq();
        @(negedge clk);
        rst = 1'b0;
        bus.exec_busy = 1'b0;
        #1;
        checkOutput("rst_cycle_pc_ena", 32'(bus.pc_ena), 32'd0);
        checkOutput("rst_cycle_epc_we", 32'(bus.epc_we), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("rst_pc_ena", 32'(bus.pc_ena), 32'd0);
        checkOutput("rst_halted", 32'(bus.halted), 32'd0);
        checkOutput("rst_pc_next", bus.pc_next, RESET_PC_TB);
        checkOutput("rst_epc_out", bus.epc_out, RESET_PC_TB);
        checkOutput("rst_cause_out", 32'(bus.cause_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("idle_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("idle_pc_ena", 32'(bus.pc_ena), 32'd0);
        exp_epc   = RESET_PC_TB;
        exp_cause = 5'd0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual no finish required finish by %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        instr_t      ri;
        instr_t      zi;
        logic [31:0] cur_pc;
        logic [31:0] e_pc;
        logic        e_we;

        zi = mk(32'h0040_0040, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 5'd0, 0, 0);
        driveCtrl(zi);
        bus.imem_ready = 1'b0;
        bus.exec_busy  = 1'b0;

        //             pc            br  imm       j  jidx         jr addr          er ex cause  rdy busy    exp_pc        we  epc           cause
        vecs[0]  = '{mk(32'h0040_0000, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 5'd0,  0, 0), 32'h0040_0004, 0, 32'h0040_0000, 5'd0};
        vecs[1]  = '{mk(32'h0040_0004, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 5'd0,  2, 0), 32'h0040_0008, 0, 32'h0040_0000, 5'd0};
        vecs[2]  = '{mk(32'h0040_0010, 1, 16'hFFFE, 0, 26'h0,       0, 32'h0,        0, 0, 5'd0,  0, 0), 32'h0040_000C, 0, 32'h0040_0000, 5'd0};
        vecs[3]  = '{mk(32'h0040_0010, 0, 16'h0000, 1, 26'h0100003, 0, 32'h0,        0, 0, 5'd0,  0, 0), 32'h0040_000C, 0, 32'h0040_0000, 5'd0};
        vecs[4]  = '{mk(32'h0040_0010, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 5'd0,  0, 5), 32'h0040_0014, 0, 32'h0040_0000, 5'd0};
        vecs[5]  = '{mk(32'h0040_0020, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        1, 1, 5'd8,  0, 0), 32'h0040_0004, 1, 32'h0040_0020, 5'd8};
        vecs[6]  = '{mk(32'h0040_0004, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        1, 0, 5'd0,  0, 0), 32'h0040_0020, 0, 32'h0040_0020, 5'd8};
        vecs[7]  = '{mk(32'h0040_0030, 0, 16'h0000, 0, 26'h0,       1, 32'h0040_0102, 0, 0, 5'd0,  0, 0), 32'h0040_0004, 1, 32'h0040_0030, 5'd4};
        vecs[8]  = '{mk(32'h0040_0034, 1, 16'h0010, 1, 26'h0000055, 1, 32'h0040_0100, 0, 0, 5'd0,  1, 1), 32'h0040_0100, 0, 32'h0040_0030, 5'd4};
        vecs[9]  = '{mk(32'hFFFF_FFFC, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 0, 5'd0,  0, 0), 32'h0000_0000, 0, 32'h0040_0030, 5'd4};
        vecs[10] = '{mk(32'h7FFF_FFF0, 1, 16'h7FFF, 0, 26'h0,       0, 32'h0,        0, 0, 5'd0,  0, 0), 32'h8001_FFF0, 0, 32'h0040_0030, 5'd4};
        vecs[11] = '{mk(32'h4000_000C, 1, 16'h0004, 1, 26'h3FFFFFF, 0, 32'h0,        0, 0, 5'd0,  0, 2), 32'h4FFF_FFFC, 0, 32'h0040_0030, 5'd4};
        vecs[12] = '{mk(32'h0040_0050, 0, 16'h0000, 0, 26'h0,       1, 32'h0040_0003, 0, 1, 5'd13, 0, 0), 32'h0040_0004, 1, 32'h0040_0050, 5'd13};
        vecs[13] = '{mk(32'h0040_0060, 0, 16'h0000, 0, 26'h0,       1, 32'h0040_0200, 1, 0, 5'd0,  0, 0), 32'h0040_0050, 0, 32'h0040_0050, 5'd13};

        $display("[TB] reset and vector table");
        resetSeq();
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].in, vecs[i].exp_pc, vecs[i].exp_we);
            exp_epc   = vecs[i].exp_epc;
            exp_cause = vecs[i].exp_cause;
        end

        $display("[TB] randomized instruction stream");
        cur_pc = RESET_PC_TB;
        for (int i = 0; i < 60; i++) begin
            ri = mk(cur_pc, ($urandom_range(0, 2) == 0), 16'($urandom), ($urandom_range(0, 3) == 0),
                    26'($urandom), ($urandom_range(0, 5) == 0), $urandom, ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) != 0) ri.jr_addr[1:0] = 2'b00;
            e_pc = modelPc(ri, exp_epc);
            e_we = ri.exc_req || (ri.jr_en && ri.jr_addr[1:0] != 2'b00);
            applyStimulus(ri, e_pc, e_we);
            if (ri.exc_req) begin
                exp_epc   = ri.pc_cur;
                exp_cause = ri.exc_cause;
            end else if (e_we) begin
                exp_epc   = ri.pc_cur;
                exp_cause = 5'd4;
            end
            cur_pc = e_pc;
        end

        $display("[TB] reset during EXEC");
        @(negedge clk);
        driveCtrl(zi);
        bus.imem_ready = 1'b1;
        bus.exec_busy  = 1'b1;
        #1;
        checkOutput("abort_exec_ir_we", 32'(bus.ir_we), 32'd1);
        @(negedge clk);
        bus.exec_busy = 1'b1;
        #1;
        checkOutput("abort_exec_pc_ena", 32'(bus.pc_ena), 32'd0);
        resetSeq();

        $display("[TB] reset during UPDATE");
        @(negedge clk);
        bus.imem_ready = 1'b1;
        #1;
        checkOutput("abort_upd_ir_we", 32'(bus.ir_we), 32'd1);
        @(negedge clk);
        bus.exec_busy    = 1'b0;
        bus.exc_req      = 1'b1;
        bus.exc_cause_in = 5'd9;
        bus.pc_cur       = 32'h1234_5678;
        #1;
        checkOutput("abort_upd_exec_pc_ena", 32'(bus.pc_ena), 32'd0);
        resetSeq();

        $display("[TB] fetch stall");
        driveCtrl(zi);
`ifdef PC_FETCH_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.imem_ready = 1'b0;
            #1;
            checkOutput("to_imem_req", 32'(bus.imem_req), 32'd1);
            checkOutput("to_wait_pc_ena", 32'(bus.pc_ena), 32'd0);
        end
        @(negedge clk);
        bus.imem_ready = 1'b0;
        #1;
        checkOutput("to_pc_ena", 32'(bus.pc_ena), 32'd1);
        checkOutput("to_pc_next", bus.pc_next, EXC_VEC_TB);
        checkOutput("to_epc_we", 32'(bus.epc_we), 32'd1);
        checkOutput("to_ir_we", 32'(bus.ir_we), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("to_epc_out", bus.epc_out, 32'h0040_0040);
        checkOutput("to_cause_out", 32'(bus.cause_out), 32'd6);
        checkOutput("to_refetch", 32'(bus.imem_req), 32'd1);
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.imem_ready = 1'b0;
            #1;
            checkOutput("stall_imem_req", 32'(bus.imem_req), 32'd1);
            checkOutput("stall_pc_ena", 32'(bus.pc_ena), 32'd0);
        end
`endif
        resetSeq();

        $display("[TB] halt");
        ri = mk(32'h0040_0100, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 5'd0, 1, 1);
        ri.halt = 1'b1;
        applyStimulus(ri, 32'h0040_0104, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.imem_ready = 1'b1;
            bus.exec_busy  = 1'b0;
            bus.exc_req    = 1'b1;
            #1;
            checkOutput("halt_halted", 32'(bus.halted), 32'd1);
            checkOutput("halt_imem_req", 32'(bus.imem_req), 32'd0);
            checkOutput("halt_pc_ena", 32'(bus.pc_ena), 32'd0);
            checkOutput("halt_epc_we", 32'(bus.epc_we), 32'd0);
            checkOutput("halt_epc_out", bus.epc_out, RESET_PC_TB);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Multicycle instruction sequencer that drives the PC register's enable and next-value inputs.
- Steps each instruction through fetch, execute-wait and PC-update phases.
- Computes the next PC: sequential, branch, jump, jr, exception vector or eret.
- Holds EPC/cause for the exception path; sits between the control unit, instruction memory handshake and the PC register.

Parameters:
- RESET_PC, 32'h00400000, PC value after reset; EPC reset value.
- EXC_VECTOR, 32'h00400004, exception handler entry.
- FETCH_TIMEOUT, 8, max FETCH wait cycles; used only with PC_FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- pc_cur  in  32  current PC register value.
- imem_ready  in  1  instruction word valid this cycle.
- exec_busy  in  1  datapath multicycle op (mul/div) still running.
- br_taken  in  1  conditional branch taken.
- br_imm  in  16  branch offset (words).
- j_en  in  1  j/jal.
- j_index  in  26  jump target index.
- jr_en  in  1  jr/jalr.
- jr_addr  in  32  register jump target.
- eret_en  in  1  return from exception.
- exc_req  in  1  datapath exception (syscall/break/teq).
- exc_cause_in  in  5  cause code for exc_req.
- halt  in  1  stop after current instruction.
- imem_req  out  1  fetch request.
- ir_we  out  1  instruction-register load strobe.
- pc_ena  out  1  PC register enable.
- pc_next  out  32  PC register data_in.
- epc_out  out  32  saved exception PC.
- cause_out  out  5  latched cause.
- epc_we  out  1  one-cycle pulse when EPC/cause update.
- halted  out  1  sequencer stopped.

Behaviour:
- States: IDLE, FETCH, EXEC, UPDATE, HALTED; state register updates on posedge clk.
- Reset (rst=0 at posedge): state=IDLE; imem_req, ir_we, pc_ena, epc_we, halted = 0; pc_next=RESET_PC; epc_out=RESET_PC; cause_out=0.
- Reset mid-operation aborts immediately; no pc_ena pulse is emitted in the reset cycle.
- IDLE -> FETCH unconditionally after one cycle.
- FETCH: imem_req=1. When imem_ready=1: ir_we=1 that cycle, then -> EXEC. Otherwise stay in FETCH.
- EXEC: -> UPDATE when exec_busy=0; otherwise hold.
- UPDATE: pc_ena=1 for exactly this cycle, with pc_next stable the whole cycle. PC register samples on negedge, mid-cycle. Then -> HALTED if halt=1, else -> FETCH.
- HALTED: sticky until reset; halted=1; no outputs pulse.
- Minimum throughput: 3 cycles/instruction (FETCH, EXEC, UPDATE) when imem_ready and exec_busy are immediate.
- pc_next is combinational from inputs, evaluated in UPDATE. Priority, highest first:
  1. exc_req: EXC_VECTOR; epc_out<=pc_cur; cause_out<=exc_cause_in; epc_we=1.
  2. jr_en with jr_addr[1:0]!=0: EXC_VECTOR; epc_out<=pc_cur; cause_out<=5'd4; epc_we=1.
  3. eret_en: epc_out.
  4. jr_en: jr_addr.
  5. j_en: {pc4[31:28], j_index, 2'b00}.
  6. br_taken: pc4 + {{14{br_imm[15]}}, br_imm, 2'b00}.
  7. Otherwise: pc4.
- pc4 = pc_cur+32'd4; all adds are 32-bit and wrap modulo 2^32 with no overflow flag.
- Simultaneous exc_req and eret_en: exception wins; EPC is overwritten.
- Control inputs are ignored outside UPDATE.

Optional Feature:
- Macro PC_FETCH_TIMEOUT_EN.
- Defined: a counter runs in FETCH. If imem_ready is still 0 after FETCH_TIMEOUT cycles, go to UPDATE with pc_next=EXC_VECTOR, epc_out<=pc_cur, cause_out<=5'd6 (IBE), epc_we=1; ir_we stays 0. Counter clears on entering FETCH and on reset.
- Undefined: FETCH waits indefinitely; no counter logic.

Decomposition:
- Shared package pc_seq_pkg: state encodings, cause codes (4 AdEL, 6 IBE, 8 Sys, 9 Bp, 13 Tr), RESET_PC/EXC_VECTOR defaults.
- One sub-module, pc_next_mux: purely combinational priority select and address arithmetic. The FSM and EPC/cause registers stay in pc_seq_ctrl.

Test Plan:
- Reset release, imem_ready=1, exec_busy=0, pc_cur=0x00400000 -> ir_we in cycle 2; pc_ena pulse in cycle 4 with pc_next=0x00400004; repeats every 3 cycles.
- pc_cur=0x00400010, br_taken=1, br_imm=16'hFFFE -> pc_next=0x0040000C. Then j_en, j_index=26'h0100003 -> pc_next=0x0040000C.
- exec_busy high 5 cycles in EXEC -> pc_ena delayed exactly 5 cycles; exactly one pulse.
- exc_req=1, cause 8, eret_en=1 simultaneously, pc_cur=0x00400020 -> pc_next=0x00400004, epc_out=0x00400020, cause_out=8, epc_we=1. Next instruction with eret_en -> pc_next=0x00400020.
- jr_en, jr_addr=0x00400102 -> pc_next=EXC_VECTOR, cause_out=4. rst=0 asserted during EXEC -> IDLE next cycle, no pc_ena.
- With PC_FETCH_TIMEOUT_EN, imem_ready held 0 -> after 8 FETCH cycles, pc_next=0x00400004, cause_out=6. Without the macro -> FETCH held indefinitely.
